apple_shadow_write_queue: RTL

- Parametrised successor to the fixed-window Apple II shadow-memory writer.
- Captures qualified Apple II bus writes and filters them against N configurable page windows, or shadows everything.
- Packs each byte into a 32-bit lane-interleaved SDRAM word (lane = {addr[0], bank[0]}) and buffers it in a coalescing FIFO.
- Drains the FIFO to an SDRAM client port with a hold-until-ack handshake, so SDRAM stalls never lose bus writes until the queue fills.

---
 rtl/apple_shadow_write_queue.sv | 126 ++++++++++++
 1 files changed

// File: rtl/apple_shadow_write_queue.sv
// rtl/apple_shadow_write_queue.sv - Apple II shadow-write capture, window filter, coalescing FIFO and SDRAM issue register
module apple_shadow_write_queue #(
   parameter int                       FIFO_DEPTH        = 8,
   parameter int                       NUM_WINDOWS       = 3,
   parameter logic [NUM_WINDOWS*8-1:0] WIN_FIRST         = {8'h04, 8'h20, 8'h40},
   parameter logic [NUM_WINDOWS*8-1:0] WIN_LAST          = {8'h0B, 8'h3F, 8'h5F},
   parameter bit                       SHADOW_ALL_MEMORY = 1'b0,
   parameter int                       BANK_WIDTH        = 1,
   parameter int                       MEM_ADDR_WIDTH    = 21
) (
   input  logic                          clk_logic,
   input  logic                          system_reset_n,
   input  logic                          bus_wr_i,
   input  logic [15:0]                   bus_addr_i,
   input  logic [7:0]                    bus_data_i,
   input  logic [BANK_WIDTH-1:0]         bus_bank_i,
   input  logic                          bus_m2sel_n_i,
   output logic                          mem_wr_o,
   output logic [MEM_ADDR_WIDTH-1:0]     mem_addr_o,
   output logic [31:0]                   mem_data_o,
   output logic [3:0]                    mem_byte_en_o,
   input  logic                          mem_ack_i,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          overflow_o,
   output logic [7:0]                    drop_count_o,
   input  logic                          clear_overflow_i
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [MEM_ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
   logic [31:0]               q_data [FIFO_DEPTH];
   logic [3:0]                q_be   [FIFO_DEPTH];
   logic [AW-1:0]             rd_ptr, wr_ptr, tail_ptr;
   logic [AW:0]               count;

   logic                      in_window, qual, empty, full, pop, merge, push, drop;
   logic [BANK_WIDTH+14:0]    wide_addr;
   logic [MEM_ADDR_WIDTH-1:0] new_addr;
   logic [1:0]                lane;
   logic [3:0]                new_be;
   logic [31:0]               new_data, lane_mask;

   always_comb begin
      in_window = 1'b0;
      for (int k = 0; k < NUM_WINDOWS; k++) begin
         if (bus_addr_i[15:8] >= WIN_FIRST[k*8 +: 8] && bus_addr_i[15:8] <= WIN_LAST[k*8 +: 8])
            in_window = 1'b1;
      end
   end

   // bank[0] picks the lane, so only the upper bank bits reach the word address
   assign wide_addr = {bus_bank_i >> 1, bus_addr_i[15:1]};
   assign new_addr  = MEM_ADDR_WIDTH'(wide_addr);
   assign lane      = {bus_addr_i[0], bus_bank_i[0]};
   assign new_be    = 4'b0001 << lane;
   assign new_data  = {4{bus_data_i}};
   assign lane_mask = {{8{new_be[3]}}, {8{new_be[2]}}, {8{new_be[1]}}, {8{new_be[0]}}};

   assign qual     = bus_wr_i && !bus_m2sel_n_i && (SHADOW_ALL_MEMORY || in_window);
   assign tail_ptr = wr_ptr - AW'(1);
   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign pop      = !empty && (!mem_wr_o || mem_ack_i);
   // a lone entry leaving this cycle cannot absorb a merge; the write becomes a new entry
   assign merge    = qual && !empty && (q_addr[tail_ptr] == new_addr) && !(count == (AW+1)'(1) && pop);
   assign push     = qual && !merge && (!full || pop);
   assign drop     = qual && !merge && full && !pop;
   assign level_o  = count;

   always_ff @(posedge clk_logic) begin
      if (push) begin
         q_addr[wr_ptr] <= new_addr;
         q_data[wr_ptr] <= new_data;
         q_be[wr_ptr]   <= new_be;
      end else if (merge) begin
         q_data[tail_ptr] <= (q_data[tail_ptr] & ~lane_mask) | (new_data & lane_mask);
         q_be[tail_ptr]   <= q_be[tail_ptr] | new_be;
      end
   end

   always_ff @(posedge clk_logic or negedge system_reset_n) begin
      if (!system_reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk_logic or negedge system_reset_n) begin
      if (!system_reset_n) begin
         mem_wr_o      <= 1'b0;
         mem_addr_o    <= '0;
         mem_data_o    <= '0;
         mem_byte_en_o <= '0;
      end else if (pop) begin
         mem_wr_o      <= 1'b1;
         mem_addr_o    <= q_addr[rd_ptr];
         mem_data_o    <= q_data[rd_ptr];
         mem_byte_en_o <= q_be[rd_ptr];
      end else if (mem_wr_o && mem_ack_i) begin
         mem_wr_o <= 1'b0;
      end
   end

   always_ff @(posedge clk_logic or negedge system_reset_n) begin
      if (!system_reset_n) begin
         overflow_o   <= 1'b0;
         drop_count_o <= '0;
      end else if (clear_overflow_i) begin
         overflow_o   <= 1'b0;
         drop_count_o <= drop ? 8'd1 : 8'd0;
      end else if (drop) begin
         overflow_o <= 1'b1;
         if (drop_count_o != 8'hFF)
            drop_count_o <= drop_count_o + 8'd1;
      end
   end

endmodule
